// File: rtl/sum_group_accumulator.sv
// Sums every `group` consecutive upstream values into a widened total and
// emits one registered result (with its sum count) per group; `flush` emits a partial group.
module sum_group_accumulator #(
    parameter  int width = 8,
    parameter  int group = 4,
    localparam int cnt_w = $clog2(group + 1),
    localparam int acc_w = width + $clog2(group)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [width-1:0] up_data,
    input  logic             flush,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [acc_w-1:0] down_data,
    output logic [cnt_w-1:0] down_count
);

    logic [acc_w-1:0] acc;
    logic [cnt_w-1:0] cnt;

    logic             slot_free;
    logic             last;
    logic             accept;
    logic             emit;
    logic [acc_w-1:0] add_val;
    logic [acc_w-1:0] sum_next;
    logic [cnt_w-1:0] cnt_next;

    // Valid/ready: a transfer happens on any edge where valid & ready are both
    // high; valid never waits on ready, and up_ready is a function of registers
    // and down_ready only, so only the group-closing sum can be refused.
    assign slot_free = ~down_valid | down_ready;
    assign last      = (cnt == cnt_w'(group - 1));
    assign up_ready  = ~last | slot_free;
    assign accept    = up_valid & up_ready;
    assign emit      = slot_free & ((accept & last) | (flush & ((cnt != '0) | accept)));

    assign add_val  = accept ? acc_w'(up_data) : '0;
    assign sum_next = acc + add_val;
    assign cnt_next = cnt + cnt_w'(accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_count <= '0;
        end else if (emit) begin
            // Emitting and draining in the same edge keeps groups back-to-back.
            down_data  <= sum_next;
            down_count <= cnt_next;
            down_valid <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                acc <= sum_next;
                cnt <= cnt_next;
            end
            if (down_valid & down_ready) begin
                down_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_group_accumulator.sv
// Directed table-driven bench for sum_group_accumulator (width=8, group=4).
module tb_sum_group_accumulator;

    localparam int W  = 8;
    localparam int G  = 4;
    localparam int CW = $clog2(G + 1);
    localparam int AW = W + $clog2(G);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [W-1:0]  up_data = '0;
    logic          flush = 1'b0;
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [AW-1:0] down_data;
    logic [CW-1:0] down_count;

    sum_group_accumulator #(.width(W), .group(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .flush      (flush),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_count (down_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          uv;
        logic [W-1:0]  ud;
        logic          fl;
        logic          dr;
        logic          ur;
        logic          dv;
        logic [AW-1:0] dd;
        logic [CW-1:0] dc;
    } vec_t;

    vec_t          vecs[$];
    logic [AW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic vec_t mk(logic uv, int ud, logic fl, logic dr,
                                logic ur, logic dv, int dd, int dc);
        vec_t v;
        v.uv = uv; v.ud = W'(ud); v.fl = fl; v.dr = dr;
        v.ur = ur; v.dv = dv; v.dd = AW'(dd); v.dc = CW'(dc);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check the registered
    // outputs and the combinational up_ready before the next rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        up_valid   = v.uv;
        up_data    = v.ud;
        flush      = v.fl;
        down_ready = v.dr;
        #1;
        chk("up_ready", idx, up_ready, v.ur);
        chk("down_valid", idx, down_valid, v.dv);
        if (v.dv) begin
            chk("down_data", idx, down_data, v.dd);
            chk("down_count", idx, down_count, v.dc);
        end
        if (down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_total", idx, down_data, -1);
            end else begin
                chk("scoreboard_total", idx, down_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic pulse_reset(input int idx);
        @(negedge clk);
        rst      = 1'b1;
        up_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_down_valid", idx, down_valid, 0);
        chk("rst_down_data", idx, down_data, 0);
        chk("rst_down_count", idx, down_count, 0);
        chk("rst_up_ready", idx, up_ready, 1);
    endtask

    initial begin
        // Basic group 10,20,30,40 -> 100
        vecs.push_back(mk(1, 10, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 20, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 30, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 40, 0, 1, 1, 0, 0, 0));
        // Max values 4 x 255 -> 1020, overlapping the drain of 100
        vecs.push_back(mk(1, 255, 0, 1, 1, 1, 100, 4));
        vecs.push_back(mk(1, 255, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 255, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 255, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1020, 4));
        // 4 x 25 -> 100, then held by backpressure while 1,2,3 accumulate
        vecs.push_back(mk(1, 25, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 25, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 25, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 25, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 100, 4));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 100, 4));
        vecs.push_back(mk(1, 3, 0, 0, 1, 1, 100, 4));
        vecs.push_back(mk(1, 4, 0, 0, 0, 1, 100, 4));
        vecs.push_back(mk(1, 4, 0, 0, 0, 1, 100, 4));
        vecs.push_back(mk(1, 4, 0, 1, 1, 1, 100, 4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 10, 4));
        // Streaming 12 x 1 -> totals of 4 every fourth cycle, no bubbles
        for (int i = 0; i < 12; i++) begin
            if (i == 4 || i == 8) vecs.push_back(mk(1, 1, 0, 1, 1, 1, 4, 4));
            else                  vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4, 4));
        // Flush a partial group 5,7 -> 12/2, then flush with nothing pending
        vecs.push_back(mk(1, 5, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 12, 2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        // Flush together with the last sum -> a single full group
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4, 4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        // Flush with accept at cnt=0 -> 3/1; flush blocked by a full slot
        vecs.push_back(mk(1, 3, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 6, 1, 0, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 6, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));

        exp_q = '{100, 1020, 100, 10, 4, 4, 4, 12, 4, 3, 6};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_down_valid", -1, down_valid, 0);
        chk("reset_down_data", -1, down_data, 0);
        chk("reset_down_count", -1, down_count, 0);
        chk("reset_up_ready", -1, up_ready, 1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset mid-group discards 9+9; the next group totals 4 only
        apply(mk(1, 9, 0, 1, 1, 0, 0, 0), 100);
        apply(mk(1, 9, 0, 1, 1, 0, 0, 0), 101);
        pulse_reset(102);
        exp_q.push_back(4);
        for (int i = 0; i < 4; i++) apply(mk(1, 1, 0, 1, 1, 0, 0, 0), 103 + i);
        apply(mk(0, 0, 0, 1, 1, 1, 4, 4), 107);
        apply(mk(0, 0, 0, 1, 1, 0, 0, 0), 108);

        // Reset drops a stalled pending total
        apply(mk(1, 5, 1, 0, 1, 0, 0, 0), 110);
        apply(mk(0, 0, 0, 0, 1, 1, 5, 1), 111);
        pulse_reset(112);
        apply(mk(0, 0, 0, 1, 1, 0, 0, 0), 113);
        apply(mk(0, 0, 0, 1, 1, 0, 0, 0), 114);

        chk("scoreboard_leftover", 200, exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
